// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the PC fetch sequencer and its redirect latch.
package pc_fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC    = 32'h0040_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR = 32'h0040_0100;
  localparam int unsigned DEF_INSTR_BYTES = 4;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, UPDATE} fetch_state_e;

  typedef enum logic [1:0] {NONE, REDIRECT, TRAP} redirect_cause_e;

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a pending redirect/trap until the sequencer consumes it; trap beats redirect.
// Optional: PC_FETCH_MISALIGN_TRAP_EN turns misaligned redirect targets into traps.
module pc_redirect_latch
  import pc_fetch_pkg::*;
#(
  parameter int             N           = 32,
  parameter logic [N-1:0]   TRAP_VECTOR = N'(DEF_TRAP_VECTOR)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_consume,
  input  logic         i_redirect_valid,
  input  logic [N-1:0] i_redirect_target,
  input  logic         i_trap_valid,
  output logic         o_evt_valid,
  output logic [N-1:0] o_evt_target
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  , output logic       o_evt_misalign
`endif
);

  localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

  redirect_cause_e r_cause, w_cause;
  logic [N-1:0]    r_target, w_target;

  // Merge arriving events with the held one so a same-cycle event is visible at once.
  always_comb begin
    w_cause  = r_cause;
    w_target = r_target;
    if (i_en && i_trap_valid) begin
      w_cause  = TRAP;
      w_target = TRAP_VECTOR;
    end else if (i_en && i_redirect_valid && (r_cause != TRAP)) begin
      w_cause  = REDIRECT;
      w_target = i_redirect_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cause  <= NONE;
      r_target <= '0;
    end else if (i_consume) begin
      r_cause  <= NONE;
      r_target <= '0;
    end else begin
      r_cause  <= w_cause;
      r_target <= w_target;
    end
  end

  assign o_evt_valid = (w_cause != NONE);

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign     = (w_cause == REDIRECT) && (w_target[1:0] != 2'b00);
  assign o_evt_misalign = w_misalign;
  assign o_evt_target   = w_misalign ? TRAP_VECTOR : w_target;
`else
  assign o_evt_target   = w_target & ALIGN_MASK;
`endif

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter sequencer: one imem fetch per PC, next PC = trap > redirect > PC+4.
// Optional: PC_FETCH_MISALIGN_TRAP_EN adds the misalign_trap output.
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter int           N           = 32,
  parameter logic [N-1:0] RESET_PC    = N'(DEF_RESET_PC),
  parameter logic [N-1:0] TRAP_VECTOR = N'(DEF_TRAP_VECTOR),
  parameter int unsigned  INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc_value,
  output logic         pc_enable,
  output logic [N-1:0] pc_next,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  output logic         fetch_valid,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_target,
  input  logic         trap_valid
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  , output logic       misalign_trap
`endif
);

  localparam logic [N-1:0] PC_INC = N'(INSTR_BYTES);

  fetch_state_e r_state, w_state_d;
  logic         r_pc_enable, w_pc_enable_d;
  logic [N-1:0] r_pc_next, w_pc_next_d;
  logic         r_imem_req, w_imem_req_d;
  logic [N-1:0] r_imem_addr, w_imem_addr_d;
  logic         r_fetch_valid, w_fetch_valid_d;
  logic         w_consume;
  logic         w_evt_valid;
  logic [N-1:0] w_evt_target;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic         r_misalign, w_misalign_d, w_evt_misalign;
`endif

  pc_redirect_latch #(
    .N           (N),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_redirect_latch (
    .clk               (clk),
    .reset             (reset),
    .i_en              (r_state != IDLE),
    .i_consume         (w_consume),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .i_trap_valid      (trap_valid),
    .o_evt_valid       (w_evt_valid),
    .o_evt_target      (w_evt_target)
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    , .o_evt_misalign  (w_evt_misalign)
`endif
  );

  // Outputs are registered, so each visible effect trails its state by one cycle:
  // ack edge -> fetch_valid, next edge -> pc_enable, next edge -> PC loads and imem_req rises.
  always_comb begin
    w_state_d       = r_state;
    w_pc_enable_d   = 1'b0;
    w_pc_next_d     = r_pc_next;
    w_imem_req_d    = r_imem_req;
    w_imem_addr_d   = r_imem_addr;
    w_fetch_valid_d = r_fetch_valid;
    w_consume       = 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    w_misalign_d    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_fetch_valid_d = 1'b0;
        w_state_d       = REQ;
      end
      REQ: begin
        w_fetch_valid_d = 1'b0;
        if (!r_imem_req) begin
          // r_pc_next is what the PC register holds once this request is visible.
          w_imem_req_d  = 1'b1;
          w_imem_addr_d = r_pc_next;
        end else if (imem_ack) begin
          w_imem_req_d = 1'b0;
          w_state_d    = UPDATE;
          if (w_evt_valid) begin
            w_consume   = 1'b1;
            w_pc_next_d = w_evt_target;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            w_misalign_d = w_evt_misalign;
`endif
          end else if (stall) begin
            w_fetch_valid_d = 1'b1;
            w_state_d       = HOLD;
          end else begin
            w_fetch_valid_d = 1'b1;
            w_pc_next_d     = pc_value + PC_INC;
          end
        end
      end
      HOLD: begin
        w_fetch_valid_d = 1'b1;
        if (w_evt_valid) begin
          w_consume       = 1'b1;
          w_pc_next_d     = w_evt_target;
          w_fetch_valid_d = 1'b0;
          w_state_d       = UPDATE;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
          w_misalign_d    = w_evt_misalign;
`endif
        end else if (!stall) begin
          w_pc_next_d     = pc_value + PC_INC;
          w_fetch_valid_d = 1'b0;
          w_state_d       = UPDATE;
        end
      end
      UPDATE: begin
        w_pc_enable_d   = 1'b1;
        w_fetch_valid_d = 1'b0;
        w_state_d       = REQ;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_pc_enable   <= 1'b0;
      r_pc_next     <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
      r_fetch_valid <= 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_d;
      r_pc_enable   <= w_pc_enable_d;
      r_pc_next     <= w_pc_next_d;
      r_imem_req    <= w_imem_req_d;
      r_imem_addr   <= w_imem_addr_d;
      r_fetch_valid <= w_fetch_valid_d;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      r_misalign    <= w_misalign_d;
`endif
    end
  end

  assign pc_enable   = r_pc_enable;
  assign pc_next     = r_pc_next;
  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign fetch_valid = r_fetch_valid;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  assign misalign_trap = r_misalign;
`endif

endmodule
